// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states and access-size encodings.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: the first requester found scanning upward from start,
// wrapping at N. Tying start to zero gives fixed lowest-index priority.
module arb_picker #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    int   cand;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(start) + i) % N;
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                grant[IDX_W'(cand)] = 1'b1;
                grant_idx            = IDX_W'(cand);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Multiplexes NUM_MASTERS cache request ports onto the single axi_interface request port.
// Build option ARB_ROUND_ROBIN_EN selects round-robin; otherwise lowest index wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_MASTERS-1:0]            req_access,
    input  logic [NUM_MASTERS-1:0]            req_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_MASTERS*2-1:0]          req_size,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] req_sel,
    input  logic [NUM_MASTERS*DATA_W-1:0]     req_st_data,
    output logic [NUM_MASTERS-1:0]            req_ready,
    output logic [DATA_W-1:0]                 req_rdata,
    output logic [ADDR_W-1:0]                 mem_a,
    output logic                              mem_access,
    output logic                              mem_write,
    output logic [1:0]                        mem_size,
    output logic [DATA_W/8-1:0]               mem_sel,
    output logic [DATA_W-1:0]                 mem_st_data,
    input  logic                              mem_ready,
    input  logic [DATA_W-1:0]                 mem_data,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_id
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant_oh;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       start_ptr;
    logic                   any_req;

    arb_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (req_access),
        .start     (start_ptr),
        .grant     (win_oh),
        .grant_idx (win_idx),
        .any_req   (any_req)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    assign start_ptr = rr_ptr;

    // The search for the next grant begins just past the master served last.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr <= '0;
        end else if (state == IDLE && any_req) begin
            rr_ptr <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end
`else
    assign start_ptr = '0;
`endif

    // Payload is captured once at grant so requesters may change their inputs while BUSY.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            mem_access  <= 1'b0;
            grant_id    <= '0;
            grant_oh    <= '0;
            mem_a       <= '0;
            mem_write   <= 1'b0;
            mem_size    <= '0;
            mem_sel     <= '0;
            mem_st_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= BUSY;
                        mem_access  <= 1'b1;
                        grant_id    <= win_idx;
                        grant_oh    <= win_oh;
                        mem_a       <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        mem_write   <= req_write[win_idx];
                        mem_size    <= req_size[win_idx*2 +: 2];
                        mem_sel     <= req_sel[win_idx*STRB_W +: STRB_W];
                        mem_st_data <= req_st_data[win_idx*DATA_W +: DATA_W];
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        mem_access <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_access <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state == BUSY && mem_ready) ? grant_oh : '0;
    assign req_rdata = mem_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a 2-master and a 4-master instance checked
// against a transaction-level reference model; honours ARB_ROUND_ROBIN_EN like the RTL.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;

    logic [1:0]  req_access, req_write, req_ready;
    logic [63:0] req_addr, req_st_data;
    logic [3:0]  req_size;
    logic [7:0]  req_sel;
    logic [31:0] req_rdata, mem_a, mem_st_data, mem_data;
    logic        mem_access, mem_write, mem_ready;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [0:0]  grant_id;

    logic [3:0]   r4_access, r4_write, r4_ready;
    logic [127:0] r4_addr, r4_st_data;
    logic [7:0]   r4_size;
    logic [15:0]  r4_sel;
    logic [31:0]  r4_rdata, m4_a, m4_st_data, m4_data;
    logic         m4_access, m4_write, m4_ready;
    logic [1:0]   m4_size;
    logic [3:0]   m4_sel;
    logic [1:0]   g4_id;

    int total = 0;
    int bad   = 0;
    int ptr2  = 0;
    int ptr4  = 0;
    int last_gid2 = 0;

    always #5 aclk = ~aclk;

    mem_port_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_access(req_access), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_sel(req_sel), .req_st_data(req_st_data),
        .req_ready(req_ready), .req_rdata(req_rdata),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_ready(mem_ready), .mem_data(mem_data), .grant_id(grant_id)
    );

    mem_port_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .req_access(r4_access), .req_write(r4_write), .req_addr(r4_addr),
        .req_size(r4_size), .req_sel(r4_sel), .req_st_data(r4_st_data),
        .req_ready(r4_ready), .req_rdata(r4_rdata),
        .mem_a(m4_a), .mem_access(m4_access), .mem_write(m4_write),
        .mem_size(m4_size), .mem_sel(m4_sel), .mem_st_data(m4_st_data),
        .mem_ready(m4_ready), .mem_data(m4_data), .grant_id(g4_id)
    );

    // Winner is the requester at the smallest circular distance from the start pointer.
    function automatic int model_pick(input logic [7:0] req, input int start, input int n);
        int best  = -1;
        int bestd = n;
        for (int i = 0; i < n; i++) begin
            if (req[i]) begin
                int d = (i - start + n) % n;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic int model_next_ptr(input int winner, input int n);
        return RR_EN ? (winner + 1) % n : 0;
    endfunction

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic do_reset();
        tick();
        aresetn = 1'b0; req_access = '0; mem_ready = 1'b0; r4_access = '0; m4_ready = 1'b0;
        tick();
        aresetn = 1'b1;
        ptr2 = 0; ptr4 = 0; last_gid2 = 0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; req_access = 2'b11; mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
        r4_access = 4'hF; m4_ready = 1'b1; m4_data = 32'h1234_5678;
        tick(); #1;
        total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_access: got %b want 0", mem_access); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL rst_req_ready: got %b want 00", req_ready); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("[TB] FAIL rst_grant_id: got %0d want 0", grant_id); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem_a: got %h want 0", mem_a); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_write: got %b want 0", mem_write); end
        total++; if (mem_size !== 2'b00) begin bad++; $display("[TB] FAIL rst_mem_size: got %b want 00", mem_size); end
        total++; if (mem_sel !== 4'h0) begin bad++; $display("[TB] FAIL rst_mem_sel: got %h want 0", mem_sel); end
        total++; if (mem_st_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem_st_data: got %h want 0", mem_st_data); end
        total++; if (m4_access !== 1'b0) begin bad++; $display("[TB] FAIL rst4_mem_access: got %b want 0", m4_access); end
        total++; if (r4_ready !== 4'h0) begin bad++; $display("[TB] FAIL rst4_req_ready: got %b want 0000", r4_ready); end
        total++; if (g4_id !== 2'd0) begin bad++; $display("[TB] FAIL rst4_grant_id: got %0d want 0", g4_id); end
        tick();
        aresetn = 1'b1; req_access = '0; mem_ready = 1'b0; r4_access = '0; m4_ready = 1'b0;
        #1;
        total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_mem_access: got %b want 0", mem_access); end
        ptr2 = 0; ptr4 = 0; last_gid2 = 0;
    endtask

    task automatic test_single_read();
        int exp;
        tick();
        req_write = 2'b00;
        req_addr  = {32'h0000_1110, 32'hBFC0_0000};
        req_size  = {2'b00, SZ_WORD};
        req_sel   = 8'hFF;
        req_access = 2'b01;
        exp = model_pick({6'b0, req_access}, ptr2, 2);
        #1;
        total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL rd_latency_t: got %b want 0", mem_access); end
        ptr2 = model_next_ptr(exp, 2);
        last_gid2 = exp;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin mem_ready = 1'b1; mem_data = 32'h3C1D_0000; end
            #1;
            total++; if (mem_access !== 1'b1) begin bad++; $display("[TB] FAIL rd_access_t%0d: got %b want 1", c, mem_access); end
            total++; if (mem_a !== 32'hBFC0_0000) begin bad++; $display("[TB] FAIL rd_mem_a_t%0d: got %h want bfc00000", c, mem_a); end
            total++; if (mem_write !== 1'b0) begin bad++; $display("[TB] FAIL rd_mem_write_t%0d: got %b want 0", c, mem_write); end
            total++; if (mem_size !== SZ_WORD) begin bad++; $display("[TB] FAIL rd_mem_size_t%0d: got %b want 10", c, mem_size); end
            total++; if (grant_id !== 1'(exp)) begin bad++; $display("[TB] FAIL rd_grant_t%0d: got %0d want %0d", c, grant_id, exp); end
            if (c == 3) begin
                total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL rd_ready: got %b want 01", req_ready); end
                total++; if (req_rdata !== 32'h3C1D_0000) begin bad++; $display("[TB] FAIL rd_rdata: got %h want 3c1d0000", req_rdata); end
            end else begin
                total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL rd_early_ready_t%0d: got %b want 00", c, req_ready); end
            end
        end
        tick();
        mem_ready = 1'b0; req_access = 2'b00;
        #1;
        total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle_t4: got %b want 0", mem_access); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL rd_ready_t4: got %b want 00", req_ready); end
        total++; if (mem_a !== 32'hBFC0_0000) begin bad++; $display("[TB] FAIL rd_hold_mem_a: got %h want bfc00000", mem_a); end
    endtask

    task automatic test_write_hold();
        tick();
        req_write   = 2'b10;
        req_addr    = {32'h1FAF_0000, 32'h0000_0040};
        req_size    = {SZ_HALF, SZ_BYTE};
        req_sel     = {4'b0011, 4'b1000};
        req_st_data = {32'h0000_BEEF, 32'h5555_AAAA};
        req_access  = 2'b10;
        #1;
        total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL wr_latency_t: got %b want 0", mem_access); end
        ptr2 = model_next_ptr(1, 2);
        last_gid2 = 1;
        tick();
        req_addr[63:32] = 32'hFFFF_FFFF; req_st_data[63:32] = $urandom; req_sel[7:4] = 4'b1100; req_write[1] = 1'b0;
        #1;
        total++; if (mem_access !== 1'b1) begin bad++; $display("[TB] FAIL wr_access: got %b want 1", mem_access); end
        total++; if (grant_id !== 1'b1) begin bad++; $display("[TB] FAIL wr_grant: got %0d want 1", grant_id); end
        total++; if (mem_a !== 32'h1FAF_0000) begin bad++; $display("[TB] FAIL wr_mem_a: got %h want 1faf0000", mem_a); end
        total++; if (mem_write !== 1'b1) begin bad++; $display("[TB] FAIL wr_mem_write: got %b want 1", mem_write); end
        total++; if (mem_sel !== 4'b0011) begin bad++; $display("[TB] FAIL wr_mem_sel: got %b want 0011", mem_sel); end
        total++; if (mem_size !== SZ_HALF) begin bad++; $display("[TB] FAIL wr_mem_size: got %b want 01", mem_size); end
        total++; if (mem_st_data !== 32'h0000_BEEF) begin bad++; $display("[TB] FAIL wr_st_data: got %h want 0000beef", mem_st_data); end
        tick();
        req_access = 2'b00;
        #1;
        total++; if (mem_access !== 1'b1) begin bad++; $display("[TB] FAIL wr_drop_access: got %b want 1", mem_access); end
        total++; if (mem_a !== 32'h1FAF_0000) begin bad++; $display("[TB] FAIL wr_drop_mem_a: got %h want 1faf0000", mem_a); end
        tick();
        mem_ready = 1'b1; mem_data = $urandom;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL wr_ready: got %b want 10", req_ready); end
        total++; if (mem_sel !== 4'b0011) begin bad++; $display("[TB] FAIL wr_sel_at_ready: got %b want 0011", mem_sel); end
        tick();
        mem_ready = 1'b0;
        #1;
        total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL wr_idle: got %b want 0", mem_access); end
    endtask

    task automatic test_spurious_ready();
        for (int c = 0; c < 3; c++) begin
            tick();
            req_access = 2'b00; mem_ready = 1'b1; mem_data = $urandom;
            #1;
            total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL spur_ready_%0d: got %b want 00", c, req_ready); end
            total++; if (grant_id !== 1'(last_gid2)) begin bad++; $display("[TB] FAIL spur_grant_%0d: got %0d want %0d", c, grant_id, last_gid2); end
            total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL spur_access_%0d: got %b want 0", c, mem_access); end
        end
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  exp, lat;
        logic [31:0] d;
        bit  got;
        do_reset();
        req_addr   = {32'h1000_0001, 32'h1000_0000};
        req_access = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick(); #1;
                if (mem_access === 1'b1) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++; $display("[TB] FAIL b2b_timeout_%0d: got no mem_access want grant", k);
            end else begin
                exp = model_pick({6'b0, req_access}, ptr2, 2);
                ptr2 = model_next_ptr(exp, 2);
                last_gid2 = exp;
                total++; if (grant_id !== 1'(exp)) begin bad++; $display("[TB] FAIL b2b_grant_%0d: got %0d want %0d", k, grant_id, exp); end
                total++; if (mem_a !== 32'h1000_0000 + 32'(exp)) begin bad++; $display("[TB] FAIL b2b_mem_a_%0d: got %h want %h", k, mem_a, 32'h1000_0000 + 32'(exp)); end
                lat = $urandom_range(0, 2);
                for (int c = 0; c < lat; c++) begin
                    tick(); #1;
                    total++; if (mem_access !== 1'b1) begin bad++; $display("[TB] FAIL b2b_hold_%0d: got %b want 1", k, mem_access); end
                end
                tick();
                d = $urandom; mem_ready = 1'b1; mem_data = d;
                #1;
                total++; if (req_ready !== (2'b01 << exp)) begin bad++; $display("[TB] FAIL b2b_ready_%0d: got %b want %b", k, req_ready, 2'b01 << exp); end
                total++; if (req_rdata !== d) begin bad++; $display("[TB] FAIL b2b_rdata_%0d: got %h want %h", k, req_rdata, d); end
                tick();
                mem_ready = 1'b0;
                #1;
                total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap_%0d: got %b want 0", k, mem_access); end
            end
        end
        req_access = 2'b00;
    endtask

    task automatic test_reset_mid_busy();
        bit got = 1'b0;
        tick();
        req_addr[63:32] = 32'h2222_0000;
        req_access = 2'b10;
        for (int c = 0; c < 8 && !got; c++) begin
            tick(); #1;
            if (mem_access === 1'b1) got = 1'b1;
        end
        total++; if (!got || grant_id !== 1'b1) begin bad++; $display("[TB] FAIL rmb_grant: got access=%b id=%0d want access=1 id=1", got, grant_id); end
        tick();
        aresetn = 1'b0; req_access = 2'b00;
        tick();
        aresetn = 1'b1;
        ptr2 = 0; ptr4 = 0; last_gid2 = 0;
        #1;
        total++; if (mem_access !== 1'b0) begin bad++; $display("[TB] FAIL rmb_access: got %b want 0", mem_access); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("[TB] FAIL rmb_grant_id: got %0d want 0", grant_id); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("[TB] FAIL rmb_mem_a: got %h want 0", mem_a); end
        for (int c = 0; c < 2; c++) begin
            tick();
            mem_ready = 1'b1; mem_data = $urandom;
            #1;
            total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL rmb_late_ready_%0d: got %b want 00", c, req_ready); end
        end
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_four_masters();
        int  exp, lat;
        logic [3:0]  req;
        logic [31:0] d;
        bit  got;
        tick();
        for (int m = 0; m < 4; m++) begin
            r4_addr[m*32 +: 32] = 32'h4000_0000 + 32'(m);
            r4_size[m*2 +: 2]   = SZ_WORD;
            r4_sel[m*4 +: 4]    = 4'hF;
        end
        for (int k = 0; k < 17; k++) begin
            req = (k < 5) ? 4'hF : 4'($urandom_range(1, 15));
            r4_access = req;
            exp = model_pick({4'b0, req}, ptr4, 4);
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick(); #1;
                if (m4_access === 1'b1) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++; $display("[TB] FAIL q4_timeout_%0d: got no mem_access want grant %0d", k, exp);
            end else begin
                ptr4 = model_next_ptr(exp, 4);
                total++; if (g4_id !== 2'(exp)) begin bad++; $display("[TB] FAIL q4_grant_%0d: got %0d want %0d (req %b)", k, g4_id, exp, req); end
                total++; if (m4_a !== 32'h4000_0000 + 32'(exp)) begin bad++; $display("[TB] FAIL q4_mem_a_%0d: got %h want %h", k, m4_a, 32'h4000_0000 + 32'(exp)); end
                lat = $urandom_range(0, 2);
                for (int c = 0; c < lat; c++) tick();
                tick();
                d = $urandom; m4_ready = 1'b1; m4_data = d;
                #1;
                total++; if (r4_ready !== (4'b0001 << exp)) begin bad++; $display("[TB] FAIL q4_ready_%0d: got %b want %b", k, r4_ready, 4'b0001 << exp); end
                total++; if (r4_rdata !== d) begin bad++; $display("[TB] FAIL q4_rdata_%0d: got %h want %h", k, r4_rdata, d); end
                tick();
                m4_ready = 1'b0;
                #1;
                total++; if (m4_access !== 1'b0) begin bad++; $display("[TB] FAIL q4_gap_%0d: got %b want 0", k, m4_access); end
            end
        end
        r4_access = 4'h0;
    endtask

    task automatic test_random_traffic();
        bit          m_busy = 1'b0;
        int          m_gid = 0, w;
        logic [31:0] m_addr = '0, m_sdata = '0;
        logic        m_write = 1'b0;
        logic [1:0]  m_size = '0, exp_ready;
        logic [3:0]  m_sel = '0;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                req_write[m]            = 1'($urandom);
                req_addr[m*32 +: 32]    = $urandom;
                req_size[m*2 +: 2]      = 2'($urandom_range(0, 2));
                req_sel[m*4 +: 4]       = 4'($urandom);
                req_st_data[m*32 +: 32] = $urandom;
            end
            if (m_busy) begin
                req_access = 2'($urandom) | (2'b01 << m_gid);
                mem_ready  = ($urandom_range(0, 2) == 0);
            end else begin
                req_access = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
                mem_ready  = 1'($urandom);
            end
            mem_data = $urandom;
            #1;
            exp_ready = (m_busy && mem_ready) ? (2'b01 << m_gid) : 2'b00;
            total++; if (mem_access !== m_busy) begin bad++; $display("[TB] FAIL rnd_access_c%0d: got %b want %b", cyc, mem_access, m_busy); end
            total++; if (grant_id !== 1'(m_gid)) begin bad++; $display("[TB] FAIL rnd_grant_c%0d: got %0d want %0d", cyc, grant_id, m_gid); end
            total++; if (mem_a !== m_addr) begin bad++; $display("[TB] FAIL rnd_mem_a_c%0d: got %h want %h", cyc, mem_a, m_addr); end
            total++; if (mem_write !== m_write) begin bad++; $display("[TB] FAIL rnd_write_c%0d: got %b want %b", cyc, mem_write, m_write); end
            total++; if (mem_size !== m_size) begin bad++; $display("[TB] FAIL rnd_size_c%0d: got %b want %b", cyc, mem_size, m_size); end
            total++; if (mem_sel !== m_sel) begin bad++; $display("[TB] FAIL rnd_sel_c%0d: got %h want %h", cyc, mem_sel, m_sel); end
            total++; if (mem_st_data !== m_sdata) begin bad++; $display("[TB] FAIL rnd_st_data_c%0d: got %h want %h", cyc, mem_st_data, m_sdata); end
            total++; if (req_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready_c%0d: got %b want %b", cyc, req_ready, exp_ready); end
            total++; if (req_rdata !== mem_data) begin bad++; $display("[TB] FAIL rnd_rdata_c%0d: got %h want %h", cyc, req_rdata, mem_data); end
            if (m_busy) begin
                if (mem_ready) m_busy = 1'b0;
            end else if (req_access != 2'b00) begin
                w       = model_pick({6'b0, req_access}, ptr2, 2);
                m_gid   = w;
                m_addr  = req_addr[w*32 +: 32];
                m_write = req_write[w];
                m_size  = req_size[w*2 +: 2];
                m_sel   = req_sel[w*4 +: 4];
                m_sdata = req_st_data[w*32 +: 32];
                m_busy  = 1'b1;
                ptr2    = model_next_ptr(w, 2);
            end
        end
        tick();
        req_access = 2'b00; mem_ready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        req_access = '0; req_write = '0; req_addr = '0; req_size = '0; req_sel = '0; req_st_data = '0;
        mem_ready = 1'b0; mem_data = '0;
        r4_access = '0; r4_write = '0; r4_addr = '0; r4_size = '0; r4_sel = '0; r4_st_data = '0;
        m4_ready = 1'b0; m4_data = '0;
        test_reset();
        test_single_read();
        test_write_hold();
        test_spurious_ready();
        test_back_to_back();
        test_reset_mid_busy();
        test_four_masters();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
